// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: default widths and vectors, redirect
// class ranks and the PC unit state encoding.
package fetch_pkg;

  localparam int          XLEN_DEFAULT         = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT   = 32'h8000_0180;
  localparam int          INSTR_BYTES_DEFAULT  = 4;

  // Redirect class ranks. A higher value wins. The current and buffered
  // ranks never tie, so a strict compare decides every contest.
  typedef logic [1:0] rank_t;
  localparam rank_t RANK_BUF_BRJ = 2'd0;
  localparam rank_t RANK_CUR_BRJ = 2'd1;
  localparam rank_t RANK_BUF_EXC = 2'd2;
  localparam rank_t RANK_CUR_EXC = 2'd3;

  // PC unit states. BOOT marks the first edge after reset, RUN means the
  // buffer is empty and HELD means a redirect is buffered.
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;

endpackage

// File: rtl/pc_redirect_merge.sv
// Combinational redirect merge. It picks the current request (exc > br > jmp),
// turns a misaligned br/jmp target into an exception-class request, and ranks
// the result against the buffered redirect.
module pc_redirect_merge
  import fetch_pkg::*;
#(
  parameter int               XLEN        = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  EXC_VECTOR  = XLEN'(EXC_VECTOR_DEFAULT),
  parameter int               INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            exc_valid,
  input  logic            buf_valid,
  input  logic            buf_exc,
  input  logic [XLEN-1:0] buf_target,
  output logic            cur_valid,
  output logic            cur_exc,
  output logic [XLEN-1:0] cur_target,
  output logic            cur_misalign,
  output logic            take_cur,
  output logic            eff_valid,
  output logic [XLEN-1:0] eff_target
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

  logic            brj_valid;
  logic [XLEN-1:0] brj_target;
  rank_t           cur_rank;
  rank_t           buf_rank;

  // Choose the current request. A branch beats a jump in the same cycle. A
  // misaligned winner is turned into an exception before ranking.
  always_comb begin
    brj_valid    = br_taken | jmp_valid;
    brj_target   = br_taken ? br_target : jmp_target;
    cur_valid    = exc_valid | brj_valid;
    cur_exc      = 1'b0;
    cur_target   = brj_target;
    cur_misalign = 1'b0;
    if (exc_valid) begin
      cur_exc    = 1'b1;
      cur_target = EXC_VECTOR;
    end else if (brj_valid && ((brj_target & ALIGN_MASK) != '0)) begin
      cur_exc      = 1'b1;
      cur_target   = EXC_VECTOR;
      cur_misalign = 1'b1;
    end
  end

  // Rank the current request against the buffer. The winner is both the
  // redirect to apply and the request allowed to overwrite the buffer.
  always_comb begin
    cur_rank   = cur_exc ? RANK_CUR_EXC : RANK_CUR_BRJ;
    buf_rank   = buf_exc ? RANK_BUF_EXC : RANK_BUF_BRJ;
    take_cur   = cur_valid && (!buf_valid || (cur_rank > buf_rank));
    eff_valid  = cur_valid | buf_valid;
    eff_target = take_cur ? cur_target : buf_target;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register. It steps sequentially, takes ranked redirects, freezes
// on stall, and buffers one redirect that arrives while fetch is frozen.
module pc_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter logic [XLEN-1:0]  EXC_VECTOR   = XLEN'(EXC_VECTOR_DEFAULT),
  parameter int               INSTR_BYTES  = INSTR_BYTES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            exc_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            pc_valid,
  output logic            misalign,
  output logic            redirect_pending
);

  logic [1:0]      state;
  logic            buf_valid;
  logic            buf_exc;
  logic [XLEN-1:0] buf_target;

  logic            cur_valid;
  logic            cur_exc;
  logic [XLEN-1:0] cur_target;
  logic            cur_misalign;
  logic            take_cur;
  logic            eff_valid;
  logic [XLEN-1:0] eff_target;

  pc_redirect_merge #(
    .XLEN        (XLEN),
    .EXC_VECTOR  (EXC_VECTOR),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_merge (
    .br_taken     (br_taken),
    .br_target    (br_target),
    .jmp_valid    (jmp_valid),
    .jmp_target   (jmp_target),
    .exc_valid    (exc_valid),
    .buf_valid    (buf_valid),
    .buf_exc      (buf_exc),
    .buf_target   (buf_target),
    .cur_valid    (cur_valid),
    .cur_exc      (cur_exc),
    .cur_target   (cur_target),
    .cur_misalign (cur_misalign),
    .take_cur     (take_cur),
    .eff_valid    (eff_valid),
    .eff_target   (eff_target)
  );

  // Sequential successor. It wraps modulo 2^XLEN and drops the carry out.
  always_comb begin
    pc_plus = pc + XLEN'(INSTR_BYTES);
  end

  assign redirect_pending = buf_valid;

  // PC, buffer and state update. Reset wins over stalls and pending redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_BOOT;
      pc         <= RESET_VECTOR;
      pc_valid   <= 1'b0;
      misalign   <= 1'b0;
      buf_valid  <= 1'b0;
      buf_exc    <= 1'b0;
      buf_target <= '0;
    end else begin
      misalign <= 1'b0;
      case (state)
        ST_BOOT: begin
          pc_valid <= 1'b1;
          state    <= ST_RUN;
        end
        ST_RUN, ST_HELD: begin
          misalign <= take_cur & cur_misalign;
          if (stall) begin
            if (take_cur) begin
              buf_valid  <= 1'b1;
              buf_exc    <= cur_exc;
              buf_target <= cur_target;
              state      <= ST_HELD;
            end
          end else begin
            pc        <= eff_valid ? eff_target : pc_plus;
            buf_valid <= 1'b0;
            buf_exc   <= 1'b0;
            state     <= ST_RUN;
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a table of directed vectors plus a
// hand-written long-stall sequence.
module tb_pc_unit;

  localparam logic [31:0] EXC = 32'h8000_0180;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic        exc_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic        pc_valid;
  logic        misalign;
  logic        redirect_pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] brt;
    logic        jmp;
    logic [31:0] jmpt;
    logic        exc;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic        exp_mis;
    logic        exp_pend;
  } vec_t;

  vec_t vecs[$];

  pc_unit dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .jmp_valid        (jmp_valid),
    .jmp_target       (jmp_target),
    .exc_valid        (exc_valid),
    .pc               (pc),
    .pc_plus          (pc_plus),
    .pc_valid         (pc_valid),
    .misalign         (misalign),
    .redirect_pending (redirect_pending)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(string n, logic r, logic s, logic b, logic [31:0] bt,
                              logic j, logic [31:0] jt, logic e, logic [31:0] epc,
                              logic ev, logic em, logic ep);
    vec_t v;
    v.name = n; v.rst = r; v.stall = s; v.br = b; v.brt = bt; v.jmp = j;
    v.jmpt = jt; v.exc = e; v.exp_pc = epc; v.exp_valid = ev; v.exp_mis = em;
    v.exp_pend = ep;
    return v;
  endfunction

  // Drives one cycle of inputs, then samples 1 time unit after the edge.
  task automatic applyStimulus(input logic r, input logic s, input logic b,
                               input logic [31:0] bt, input logic j,
                               input logic [31:0] jt, input logic e);
    rst = r; stall = s; br_taken = b; br_target = bt;
    jmp_valid = j; jmp_target = jt; exc_valid = e;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOne(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", n, got, want);
    end
  endtask

  task automatic checkOutput(input string n, input logic [31:0] epc, input logic ev,
                             input logic em, input logic ep);
    logic [31:0] eplus;
    eplus = epc + 32'd4;
    checkOne({n, ".pc"}, pc, epc);
    checkOne({n, ".pc_plus"}, pc_plus, eplus);
    checkOne({n, ".pc_valid"}, 32'(pc_valid), 32'(ev));
    checkOne({n, ".misalign"}, 32'(misalign), 32'(em));
    checkOne({n, ".pending"}, 32'(redirect_pending), 32'(ep));
  endtask

  // Main test: vector table, then the long-stall sequence, then summary.
  initial begin
    vecs.push_back(mk("rst0",      1,0, 0,0,      0,0,      0, 32'h0,        0,0,0));
    vecs.push_back(mk("rst1",      1,0, 0,0,      0,0,      0, 32'h0,        0,0,0));
    vecs.push_back(mk("boot",      0,0, 1,32'h900,0,0,      0, 32'h0,        1,0,0));
    vecs.push_back(mk("seq4",      0,0, 0,0,      0,0,      0, 32'h4,        1,0,0));
    vecs.push_back(mk("seq8",      0,0, 0,0,      0,0,      0, 32'h8,        1,0,0));
    vecs.push_back(mk("seqC",      0,0, 0,0,      0,0,      0, 32'hC,        1,0,0));
    vecs.push_back(mk("seq10",     0,0, 0,0,      0,0,      0, 32'h10,       1,0,0));
    vecs.push_back(mk("br_vs_jmp", 0,0, 1,32'h40, 1,32'h80, 0, 32'h40,       1,0,0));
    vecs.push_back(mk("after_br",  0,0, 0,0,      0,0,      0, 32'h44,       1,0,0));
    vecs.push_back(mk("exc_vs_br", 0,0, 1,32'h100,0,0,      1, EXC,          1,0,0));
    vecs.push_back(mk("jmp20",     0,0, 0,0,      1,32'h20, 0, 32'h20,       1,0,0));
    vecs.push_back(mk("stall1",    0,1, 1,32'h100,0,0,      0, 32'h20,       1,0,1));
    vecs.push_back(mk("stall2",    0,1, 0,0,      0,0,      0, 32'h20,       1,0,1));
    vecs.push_back(mk("stall3",    0,1, 0,0,      0,0,      0, 32'h20,       1,0,1));
    vecs.push_back(mk("release",   0,0, 0,0,      0,0,      0, 32'h100,      1,0,0));
    vecs.push_back(mk("seq104",    0,0, 0,0,      0,0,      0, 32'h104,      1,0,0));
    vecs.push_back(mk("hold_exc",  0,1, 0,0,      0,0,      1, 32'h104,      1,0,1));
    vecs.push_back(mk("br_no_ovr", 0,1, 1,32'h200,0,0,      0, 32'h104,      1,0,1));
    vecs.push_back(mk("rel_exc",   0,0, 0,0,      0,0,      0, EXC,          1,0,0));
    vecs.push_back(mk("hold_br",   0,1, 1,32'h200,0,0,      0, EXC,          1,0,1));
    vecs.push_back(mk("jmp_ovr",   0,1, 0,0,      1,32'h300,0, EXC,          1,0,1));
    vecs.push_back(mk("rel_jmp",   0,0, 0,0,      0,0,      0, 32'h300,      1,0,0));
    vecs.push_back(mk("hold_br2",  0,1, 1,32'h400,0,0,      0, 32'h300,      1,0,1));
    vecs.push_back(mk("rel_newj",  0,0, 0,0,      1,32'h500,0, 32'h500,      1,0,0));
    vecs.push_back(mk("hold_exc2", 0,1, 0,0,      0,0,      1, 32'h500,      1,0,1));
    vecs.push_back(mk("rel_bufex", 0,0, 1,32'h700,0,0,      0, EXC,          1,0,0));
    vecs.push_back(mk("mis_br",    0,0, 1,32'h42, 0,0,      0, EXC,          1,1,0));
    vecs.push_back(mk("mis_end",   0,0, 0,0,      0,0,      0, EXC+32'd4,    1,0,0));
    vecs.push_back(mk("mis_stall", 0,1, 0,0,      1,32'h13, 0, EXC+32'd4,    1,1,1));
    vecs.push_back(mk("mis_rel",   0,0, 0,0,      0,0,      0, EXC,          1,0,0));
    vecs.push_back(mk("jmp_high",  0,0, 0,0,      1,32'hFFFF_FFF8,0, 32'hFFFF_FFF8, 1,0,0));
    vecs.push_back(mk("top",       0,0, 0,0,      0,0,      0, 32'hFFFF_FFFC,1,0,0));
    vecs.push_back(mk("wrap",      0,0, 0,0,      0,0,      0, 32'h0,        1,0,0));
    vecs.push_back(mk("seq4b",     0,0, 0,0,      0,0,      0, 32'h4,        1,0,0));
    vecs.push_back(mk("hold_br3",  0,1, 1,32'h800,0,0,      0, 32'h4,        1,0,1));
    vecs.push_back(mk("rst_held",  1,1, 0,0,      0,0,      0, 32'h0,        0,0,0));
    vecs.push_back(mk("boot2",     0,0, 0,0,      0,0,      0, 32'h0,        1,0,0));
    vecs.push_back(mk("no_stale",  0,0, 0,0,      0,0,      0, 32'h4,        1,0,0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].brt,
                    vecs[i].jmp, vecs[i].jmpt, vecs[i].exc);
      checkOutput(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_valid,
                  vecs[i].exp_mis, vecs[i].exp_pend);
    end

    // Long stall at pc=0x4. An exception is buffered, then a misaligned
    // branch (exception class) overwrites it. pc_valid stays high
    // throughout, and misalign pulses only in the cycle the branch is taken.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("ls_idle", 32'h4, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    checkOutput("ls_exc", 32'h4, 1, 0, 1);
    applyStimulus(0, 1, 0, 0, 1, 32'h600, 0);
    checkOutput("ls_jmp_lose", 32'h4, 1, 0, 1);
    applyStimulus(0, 1, 1, 32'h61, 0, 0, 0);
    checkOutput("ls_mis", 32'h4, 1, 1, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("ls_mis_drop", 32'h4, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("ls_release", EXC, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("ls_seq", EXC + 32'd4, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
